// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-read-port register file with a sequential clear FSM and registered reads.
// Optional write-first bypass on same-edge read/write: define REGFILE_BYPASS_EN.
module regfile_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_READ*$clog2(NUM_REGS)-1:0] readReg,
    output logic [NUM_READ*DATA_WIDTH-1:0]   readData,
    input  logic [$clog2(NUM_REGS)-1:0]      writeReg,
    input  logic [DATA_WIDTH-1:0]            writeData,
    input  logic                             write,
    input  logic                             clear,
    output logic                             ready
);
    localparam int ADDR_W = $clog2(NUM_REGS);
    localparam logic [ADDR_W:0]   REG_LIMIT = (ADDR_W+1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t              state, next_state;
    logic [ADDR_W-1:0]   clr_idx, next_idx;
    logic [DATA_WIDTH-1:0] mem [NUM_REGS];
    logic                wr_accept;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < REG_LIMIT;
    endfunction

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_CLEAR;
            clr_idx <= '0;
        end else begin
            state   <= next_state;
            clr_idx <= next_idx;
        end
    end

    always_comb begin
        next_state = state;
        next_idx   = clr_idx;
        case (state)
            S_CLEAR: begin
                if (clr_idx == LAST_IDX) begin
                    next_state = S_READY;
                    next_idx   = '0;
                end else begin
                    next_idx = clr_idx + 1'b1;
                end
            end
            S_READY: begin
                if (clear) begin
                    next_state = S_CLEAR;
                    next_idx   = '0;
                end
            end
            default: begin
                next_state = S_CLEAR;
                next_idx   = '0;
            end
        endcase
    end

    assign ready = (state == S_READY);

    // A write coinciding with a clear request is dropped, so it neither lands nor bypasses.
    assign wr_accept = (state == S_READY) && write && !clear &&
                       in_range(writeReg) && !is_zero_reg(writeReg);

    always_ff @(posedge clk) begin
        if (state == S_CLEAR) begin
            mem[clr_idx] <= '0;
        end else if (wr_accept) begin
            mem[writeReg] <= writeData;
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [ADDR_W-1:0]     raddr;
        logic [DATA_WIDTH-1:0] rnext;
        logic [DATA_WIDTH-1:0] rdata_q;

        assign raddr = readReg[k*ADDR_W +: ADDR_W];

        always_comb begin
            rnext = '0;
            if (in_range(raddr) && !is_zero_reg(raddr)) begin
                rnext = mem[raddr];
            end
`ifdef REGFILE_BYPASS_EN
            if (wr_accept && (raddr == writeReg)) begin
                rnext = writeData;
            end
`endif
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rdata_q <= '0;
            end else if (state == S_CLEAR) begin
                rdata_q <= '0;
            end else begin
                rdata_q <= rnext;
            end
        end

        assign readData[k*DATA_WIDTH +: DATA_WIDTH] = rdata_q;
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - randomized bench for regfile_mp comparing two configurations against a reference model.
module tb_regfile_mp;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  ra [4];
    logic [4:0]  wreg = '0;
    logic [31:0] wdata = '0;
    logic        wr = 1'b0;
    logic        clr = 1'b0;

    logic [9:0]  read_reg_a;
    logic [14:0] read_reg_b;
    logic [63:0] read_data_a;
    logic [95:0] read_data_b;
    logic        ready_a, ready_b;

    int checks = 0;
    int errors = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // instance 0: 32 regs, 2 ports, x0 hardwired; instance 1: 24 regs, 3 ports, x0 ordinary
    int          nregs [2] = '{32, 24};
    int          nread [2] = '{2, 3};
    bit          zero  [2] = '{1'b1, 1'b0};
    logic [31:0] mmem   [2][32];
    logic [31:0] exp_rd [2][4];
    int          clear_left [2];

    assign read_reg_a = {ra[1], ra[0]};
    assign read_reg_b = {ra[2], ra[1], ra[0]};

    regfile_mp #(.DATA_WIDTH(32), .NUM_REGS(32), .NUM_READ(2), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst(rst), .readReg(read_reg_a), .readData(read_data_a),
        .writeReg(wreg), .writeData(wdata), .write(wr), .clear(clr), .ready(ready_a)
    );

    regfile_mp #(.DATA_WIDTH(32), .NUM_REGS(24), .NUM_READ(3), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst(rst), .readReg(read_reg_b), .readData(read_data_b),
        .writeReg(wreg), .writeData(wdata), .write(wr), .clear(clr), .ready(ready_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            clear_left[d] = nregs[d];
            for (int k = 0; k < 4; k++) exp_rd[d][k] = '0;
        end
    endtask

    // One rising edge of the reference: clearing sweeps one register, otherwise read then write.
    task automatic model_step(input int d);
        bit accepted;
        int a;
        if (clear_left[d] > 0) begin
            mmem[d][nregs[d] - clear_left[d]] = '0;
            clear_left[d]--;
            for (int k = 0; k < 4; k++) exp_rd[d][k] = '0;
        end else begin
            accepted = wr && !clr && (int'(wreg) < nregs[d]) && !(zero[d] && wreg == 0);
            for (int k = 0; k < nread[d]; k++) begin
                a = int'(ra[k]);
                if (a >= nregs[d] || (zero[d] && a == 0))
                    exp_rd[d][k] = '0;
                else if (BYPASS && accepted && a == int'(wreg))
                    exp_rd[d][k] = wdata;
                else
                    exp_rd[d][k] = mmem[d][a];
            end
            if (accepted) mmem[d][wreg] = wdata;
            if (clr) clear_left[d] = nregs[d];
        end
    endtask

    task automatic compare_all();
        check("ready_a", {31'b0, ready_a}, {31'b0, clear_left[0] == 0});
        check("ready_b", {31'b0, ready_b}, {31'b0, clear_left[1] == 0});
        for (int k = 0; k < 2; k++)
            check($sformatf("rd_a%0d", k), read_data_a[k*32 +: 32], exp_rd[0][k]);
        for (int k = 0; k < 3; k++)
            check($sformatf("rd_b%0d", k), read_data_b[k*32 +: 32], exp_rd[1][k]);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        compare_all();
    endtask

    task automatic op(input logic w, input int wa, input logic [31:0] wd,
                      input int r0, input int r1, input int r2, input logic c);
        wr = w; wreg = 5'(wa); wdata = wd;
        ra[0] = 5'(r0); ra[1] = 5'(r1); ra[2] = 5'(r2); clr = c;
        cycle();
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        model_reset();
        #1 compare_all();
        #3 rst = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) op(0, 0, '0, 0, 0, 0, 0);
    endtask

    task automatic sweep_reads();
        for (int a = 0; a < 32; a++) op(0, 0, '0, a, (a + 1) % 32, (a + 2) % 32, 0);
        idle(1);
    endtask

    initial begin
        for (int k = 0; k < 4; k++) ra[k] = '0;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 32; i++) mmem[d][i] = $urandom;
        model_reset();
        @(posedge clk); #1;
        do_reset();
        idle(34);
        sweep_reads();

        op(1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
        op(0, 0, '0, 5, 5, 5, 0);
        idle(1);
        op(1, 0, 32'h12345678, 0, 0, 0, 0);
        op(0, 0, '0, 0, 0, 0, 0);
        idle(1);
        op(1, 7, 32'h00000001, 0, 0, 0, 0);
        op(1, 7, 32'hA5A5A5A5, 3, 7, 7, 0);
        op(0, 0, '0, 7, 7, 7, 0);
        idle(1);
        op(1, 30, 32'h000000FF, 0, 0, 0, 0);
        op(0, 0, '0, 30, 30, 30, 0);
        op(1, 23, 32'h2323CAFE, 0, 0, 0, 0);
        op(0, 0, '0, 23, 23, 23, 0);
        idle(1);

        for (int i = 0; i < 2000; i++) begin
            int wa;
            int r [3];
            wa = $urandom_range(0, 31);
            for (int k = 0; k < 3; k++)
                r[k] = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 31);
            op(1'($urandom_range(0, 1)), wa, $urandom, r[0], r[1], r[2],
               $urandom_range(0, 199) == 0);
        end
        idle(34);

        for (int i = 1; i < 32; i++) op(1, i, 32'h01010101 * i + 32'h10, 0, i, i, 0);
        op(1, 3, 32'h00000099, 3, 3, 3, 1);
        idle(33);
        sweep_reads();

        for (int i = 1; i < 32; i++) op(1, i, 32'hF0000000 | i, 0, 0, 0, 0);
        op(0, 0, '0, 0, 0, 0, 1);
        idle(10);
        do_reset();
        idle(34);
        sweep_reads();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
